chan_scan_mux: RTL and testbench

Registered, parametrised N-channel multiplexer with an optional auto-scan sequencer, used to route haptic actuator/sensor channels onto a single W-bit path. It replaces the fixed combinational 8:1 selector. It adds a registered output, a channel tag and valid flag, break-before-make blanking between channel switches, and a self-timed scan mode that cycles through all channels with a programmable dwell.

---
 rtl/chan_scan_mux_pkg.sv | 13 +
 rtl/chan_scan_mux_if.sv | 30 +++
 rtl/chan_scan_mux_scan_timer.sv | 27 ++
 rtl/chan_scan_mux.sv | 123 ++++++++++++
 tb/tb_chan_scan_mux.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/chan_scan_mux_pkg.sv
// Shared FSM state encoding and mode constants for the channel scan multiplexer.
package chan_scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/chan_scan_mux_if.sv
// Control, packed channel data and tagged output stream of the channel scan multiplexer.
interface chan_scan_mux_if #(
    parameter int N_CH    = 8,
    parameter int W       = 1,
    parameter int DWELL_W = 8
);
    localparam int SEL_W = $clog2(N_CH);

    logic                en;
    logic                mode;
    logic [SEL_W-1:0]    sel_in;
    logic [DWELL_W-1:0]  dwell;
    logic [N_CH*W-1:0]   d_in;

    logic [W-1:0]        out;
    logic [SEL_W-1:0]    out_ch;
    logic                out_valid;
    logic                wrap;

    modport master (
        output en, mode, sel_in, dwell, d_in,
        input  out, out_ch, out_valid, wrap
    );

    modport slave (
        input  en, mode, sel_in, dwell, d_in,
        output out, out_ch, out_valid, wrap
    );

endinterface

// File: rtl/chan_scan_mux_scan_timer.sv
// Shared cycle timer for blank length and dwell; expire is high on the last cycle of the interval.
// Counts elapsed cycles rather than remaining ones so the limit can change live.
module scan_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [CNT_W-1:0] limit,
    output logic             expire
);

    logic [CNT_W-1:0] elapsed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            elapsed <= '0;
        end else if (clr) begin
            elapsed <= '0;
        end else begin
            elapsed <= elapsed + CNT_W'(1);
        end
    end

    assign expire = ({1'b0, elapsed} + (CNT_W+1)'(1)) >= {1'b0, limit};

endmodule

// File: rtl/chan_scan_mux.sv
// Registered N:1 channel mux with break-before-make blanking, channel tag and auto-scan sequencer.
// Latency d_in->out is 1 cycle in HOLD; no backpressure, the output is a free-running stream.
module chan_scan_mux #(
    parameter int N_CH    = 8,
    parameter int W       = 1,
    parameter int DWELL_W = 8,
    parameter int BLANK   = 1
) (
    input logic            clk,
    input logic            rst_n,
    chan_scan_mux_if.slave bus
);
    import chan_scan_pkg::*;

    localparam int SEL_W = $clog2(N_CH);
    localparam int BLK_W = $clog2(BLANK + 2);
    localparam int CNT_W = (DWELL_W > BLK_W) ? DWELL_W : BLK_W;
    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N_CH - 1);

    state_t             state;
    logic [SEL_W-1:0]   ch;
    logic               mode_q;
    logic               wrap_pend;

    logic               sel_ok;
    logic               mode_chg;
    logic               restart;
    logic               hold_switch;
    logic               tgt_wrap;
    logic [SEL_W-1:0]   start_ch;
    logic [SEL_W-1:0]   next_ch;
    logic [SEL_W-1:0]   tgt_ch;
    logic [DWELL_W-1:0] dwell_eff;
    logic [CNT_W-1:0]   limit;
    logic               tmr_clr;
    logic               tmr_exp;
    logic [W-1:0]       d_cur;
    logic [W-1:0]       d_tgt;

    assign sel_ok   = int'(bus.sel_in) < N_CH;
    assign mode_chg = bus.mode != mode_q;
    assign restart  = (state == ST_IDLE) || mode_chg;

    // Start channel after IDLE or a mode change; next_ch is the switch target while holding.
    assign start_ch = (bus.mode == MODE_SCAN || !sel_ok) ? '0 : bus.sel_in;
    assign next_ch  = (bus.mode == MODE_SCAN) ? ((ch == LAST_CH) ? '0 : ch + SEL_W'(1))
                                              : bus.sel_in;

    assign hold_switch = (state == ST_HOLD) &&
                         ((bus.mode == MODE_SCAN) ? tmr_exp : (sel_ok && bus.sel_in != ch));

    assign tgt_ch   = restart ? start_ch : next_ch;
    assign tgt_wrap = !restart && (ch == LAST_CH) && (tgt_ch == '0);

    assign dwell_eff = (bus.dwell == '0) ? DWELL_W'(1) : bus.dwell;
    assign limit     = (state == ST_BLANK) ? CNT_W'(BLANK) : CNT_W'(dwell_eff);
    assign tmr_clr   = !bus.en || restart || hold_switch || (state == ST_BLANK && tmr_exp);

    assign d_cur = bus.d_in[int'(ch) * W +: W];
    assign d_tgt = bus.d_in[int'(tgt_ch) * W +: W];

    scan_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (tmr_clr),
        .limit  (limit),
        .expire (tmr_exp)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            ch            <= '0;
            mode_q        <= MODE_MANUAL;
            wrap_pend     <= 1'b0;
            bus.out       <= '0;
            bus.out_ch    <= '0;
            bus.out_valid <= 1'b0;
            bus.wrap      <= 1'b0;
        end else begin
            mode_q   <= bus.mode;
            bus.wrap <= 1'b0;
            if (!bus.en) begin
                state         <= ST_IDLE;
                ch            <= '0;
                wrap_pend     <= 1'b0;
                bus.out       <= '0;
                bus.out_ch    <= '0;
                bus.out_valid <= 1'b0;
            end else if (restart || hold_switch) begin
                ch <= tgt_ch;
                if (BLANK == 0) begin
                    state         <= ST_HOLD;
                    bus.out       <= d_tgt;
                    bus.out_ch    <= tgt_ch;
                    bus.out_valid <= 1'b1;
                    bus.wrap      <= tgt_wrap;
                    wrap_pend     <= 1'b0;
                end else begin
                    // out_ch keeps the old tag until the blank ends
                    state         <= ST_BLANK;
                    bus.out       <= '0;
                    bus.out_valid <= 1'b0;
                    wrap_pend     <= tgt_wrap;
                end
            end else if (state == ST_BLANK) begin
                if (tmr_exp) begin
                    state         <= ST_HOLD;
                    bus.out       <= d_cur;
                    bus.out_ch    <= ch;
                    bus.out_valid <= 1'b1;
                    bus.wrap      <= wrap_pend;
                    wrap_pend     <= 1'b0;
                end
            end else begin
                bus.out <= d_cur;
            end
        end
    end

endmodule

// File: tb/tb_chan_scan_mux.sv
// Bench for chan_scan_mux: three builds (8ch/blank1, 8ch/blank0, 5ch x 4b/blank1) driven together.
module tb_chan_scan_mux;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        en     = 1'b0;
    logic        mode   = 1'b0;
    logic [2:0]  sel_in = 3'd0;
    logic [7:0]  dwell  = 8'd0;
    logic [7:0]  d8     = 8'd0;
    logic [19:0] d20    = 20'h9C3A5;

    always #5 clk = ~clk;

    chan_scan_mux_if #(.N_CH(8), .W(1), .DWELL_W(8)) ifa ();
    chan_scan_mux_if #(.N_CH(8), .W(1), .DWELL_W(8)) ifb ();
    chan_scan_mux_if #(.N_CH(5), .W(4), .DWELL_W(8)) ifc ();

    assign ifa.en = en;  assign ifa.mode = mode;  assign ifa.sel_in = sel_in;
    assign ifa.dwell = dwell;  assign ifa.d_in = d8;
    assign ifb.en = en;  assign ifb.mode = mode;  assign ifb.sel_in = sel_in;
    assign ifb.dwell = dwell;  assign ifb.d_in = d8;
    assign ifc.en = en;  assign ifc.mode = mode;  assign ifc.sel_in = sel_in;
    assign ifc.dwell = dwell;  assign ifc.d_in = d20;

    chan_scan_mux #(.N_CH(8), .W(1), .DWELL_W(8), .BLANK(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
    chan_scan_mux #(.N_CH(8), .W(1), .DWELL_W(8), .BLANK(0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));
    chan_scan_mux #(.N_CH(5), .W(4), .DWELL_W(8), .BLANK(1)) dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc.slave));

    int checks   = 0;
    int failures = 0;

    int nch[3] = '{8, 8, 5};
    int blk[3] = '{1, 0, 1};
    int wd[3]  = '{1, 1, 4};

    // Model: phase 0 = idle, 1 = gap (blanking), 2 = live
    int m_ph[3], m_ch[3], m_gap[3], m_live[3], m_pend[3], m_prev[3];
    int m_out[3], m_tag[3], m_vld[3], m_wrap[3];
    int o_out[3], o_ch[3], o_vld[3], o_wrap[3];

    function automatic int chan(int i, int din, int c);
        return (din >> (c * wd[i])) & ((1 << wd[i]) - 1);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_ph[i] = 0; m_ch[i] = 0; m_gap[i] = 0; m_live[i] = 0; m_pend[i] = 0;
            m_prev[i] = 0; m_out[i] = 0; m_tag[i] = 0; m_vld[i] = 0; m_wrap[i] = 0;
        end
    endtask

    task automatic show(int i, int din);
        m_ph[i]   = 2;
        m_live[i] = 0;
        m_out[i]  = chan(i, din, m_ch[i]);
        m_tag[i]  = m_ch[i];
        m_vld[i]  = 1;
        m_wrap[i] = m_pend[i];
        m_pend[i] = 0;
    endtask

    task automatic enter(int i, int c, int wr, int din);
        m_ch[i]   = c;
        m_pend[i] = wr;
        if (blk[i] == 0) begin
            show(i, din);
        end else begin
            m_ph[i]  = 1;
            m_gap[i] = blk[i];
            m_out[i] = 0;
            m_vld[i] = 0;
        end
    endtask

    task automatic model_step(int i);
        int n   = nch[i];
        int dw  = (dwell == 0) ? 1 : int'(dwell);
        int s   = int'(sel_in);
        int din = (i == 2) ? int'(d20) : int'(d8);
        int nxt = 0;
        bit go  = 0;
        m_wrap[i] = 0;
        if (!en) begin
            m_ph[i] = 0; m_ch[i] = 0; m_tag[i] = 0; m_out[i] = 0; m_vld[i] = 0; m_pend[i] = 0;
        end else if (m_ph[i] == 0 || int'(mode) != m_prev[i]) begin
            enter(i, mode ? 0 : ((s < n) ? s : 0), 0, din);
        end else if (m_ph[i] == 1) begin
            m_gap[i]--;
            if (m_gap[i] == 0) show(i, din);
        end else begin
            m_live[i]++;
            if (mode && m_live[i] >= dw) begin
                go = 1; nxt = (m_ch[i] + 1) % n;
            end else if (!mode && s < n && s != m_ch[i]) begin
                go = 1; nxt = s;
            end
            if (go) enter(i, nxt, (m_ch[i] == n - 1 && nxt == 0) ? 1 : 0, din);
            else    m_out[i] = chan(i, din, m_ch[i]);
        end
        m_prev[i] = int'(mode);
    endtask

    task automatic sample();
        o_out[0] = int'(ifa.out); o_ch[0] = int'(ifa.out_ch); o_vld[0] = int'(ifa.out_valid); o_wrap[0] = int'(ifa.wrap);
        o_out[1] = int'(ifb.out); o_ch[1] = int'(ifb.out_ch); o_vld[1] = int'(ifb.out_valid); o_wrap[1] = int'(ifb.wrap);
        o_out[2] = int'(ifc.out); o_ch[2] = int'(ifc.out_ch); o_vld[2] = int'(ifc.out_valid); o_wrap[2] = int'(ifc.wrap);
    endtask

    task automatic compare_all();
        sample();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (o_out[i] != m_out[i] || o_ch[i] != m_tag[i] || o_vld[i] != m_vld[i] || o_wrap[i] != m_wrap[i]) begin
                failures++;
                $display("FAIL model_dut%0d t=%0t got out=%0d ch=%0d vld=%0d wrap=%0d want out=%0d ch=%0d vld=%0d wrap=%0d",
                         i, $time, o_out[i], o_ch[i], o_vld[i], o_wrap[i], m_out[i], m_tag[i], m_vld[i], m_wrap[i]);
            end
        end
    endtask

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // Model steps on the same edge the DUT samples; outputs are compared 4 time units later.
    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else for (int i = 0; i < 3; i++) model_step(i);
        #4;
        compare_all();
    endtask

    int fv[3], fw[3], nw[3], prv[3], per[3];
    int bad, lastb;

    initial begin
        tick();
        tick();
        chk("rst_vld", o_vld[0], 0);
        chk("rst_ch", o_ch[0], 0);
        chk("rst_out", o_out[0], 0);
        rst_n = 1'b1;

        // manual mode
        sel_in = 3'd3; d8 = 8'h08; en = 1'b1;
        tick();
        chk("man_gap_vld", o_vld[0], 0);
        chk("b_direct_ch", o_ch[1], 3);
        tick();
        chk("man_out", o_out[0], 1);
        chk("man_ch", o_ch[0], 3);
        chk("man_vld", o_vld[0], 1);
        chk("c_ch3_data", o_out[2], 12);
        d8 = 8'h00;
        tick();
        chk("man_follow0", o_out[0], 0);
        d8 = 8'hff;
        tick();
        chk("man_follow1", o_out[0], 1);
        sel_in = 3'd5;
        tick();
        chk("sw_gap_vld", o_vld[0], 0);
        chk("sw_gap_out", o_out[0], 0);
        chk("sw_gap_ch", o_ch[0], 3);
        chk("c_ignore5_ch", o_ch[2], 3);
        tick();
        chk("sw_new_ch", o_ch[0], 5);
        chk("sw_new_vld", o_vld[0], 1);
        sel_in = 3'd6;
        tick();
        tick();
        chk("c_ignore6_ch", o_ch[2], 3);
        chk("c_ignore6_vld", o_vld[2], 1);
        chk("a_sel6_ch", o_ch[0], 6);

        // scan mode, dwell 2
        mode = 1'b1; dwell = 8'd2;
        for (int i = 0; i < 3; i++) begin fv[i] = -1; fw[i] = -1; nw[i] = 0; end
        for (int k = 0; k < 80; k++) begin
            tick();
            for (int i = 0; i < 3; i++) begin
                if (fv[i] < 0 && o_vld[i] == 1 && o_ch[i] == 0) fv[i] = k;
                if (o_wrap[i] == 1) begin
                    if (fw[i] < 0) fw[i] = k;
                    nw[i]++;
                end
            end
        end
        chk("scan2_first_a", fv[0], 1);
        chk("scan2_period_a", fw[0] - fv[0], 24);
        chk("scan2_period_b", fw[1] - fv[1], 16);
        chk("scan2_period_c", fw[2] - fv[2], 15);
        chk("scan2_wraps_a", nw[0], 3);
        chk("scan2_wraps_c", nw[2], 5);

        // dwell 0 behaves as 1
        dwell = 8'd0; bad = 0; lastb = 0;
        for (int i = 0; i < 3; i++) begin prv[i] = -1; per[i] = 0; end
        for (int k = 0; k < 60; k++) begin
            tick();
            for (int i = 0; i < 3; i++) begin
                if (o_wrap[i] == 1) begin
                    if (prv[i] >= 0) per[i] = k - prv[i];
                    prv[i] = k;
                end
            end
            if (k >= 2 && !(o_vld[1] == 1 && o_ch[1] == (lastb + 1) % 8)) bad++;
            lastb = o_ch[1];
        end
        chk("scan0_period_a", per[0], 16);
        chk("scan0_period_b", per[1], 8);
        chk("scan0_period_c", per[2], 10);
        chk("b_step_bad", bad, 0);

        // enable dropped mid-HOLD, then restart
        dwell = 8'd3;
        for (int k = 0; k < 10 && o_vld[0] == 0; k++) tick();
        chk("pre_drop_vld", o_vld[0], 1);
        en = 1'b0;
        tick();
        chk("drop_vld", o_vld[0], 0);
        chk("drop_out", o_out[0], 0);
        chk("drop_ch", o_ch[0], 0);
        chk("drop_b_vld", o_vld[1], 0);
        en = 1'b1;
        tick();
        chk("restart_gap_vld", o_vld[0], 0);
        tick();
        chk("restart_ch", o_ch[0], 0);
        chk("restart_vld", o_vld[0], 1);
        chk("restart_wrap", o_wrap[0], 0);

        // asynchronous reset between edges mid-scan
        for (int k = 0; k < 40 && !(o_vld[0] == 1 && o_ch[0] != 0); k++) tick();
        chk("pre_rst_busy", (o_vld[0] == 1 && o_ch[0] != 0) ? 1 : 0, 1);
        #1 rst_n = 1'b0;
        model_reset();
        #1 compare_all();
        chk("async_vld", o_vld[0], 0);
        chk("async_ch", o_ch[0], 0);
        chk("async_out", o_out[0], 0);
        #1 rst_n = 1'b1;
        tick();
        chk("post_rst_gap_vld", o_vld[0], 0);
        tick();
        chk("post_rst_ch", o_ch[0], 0);
        chk("post_rst_vld", o_vld[0], 1);
        chk("post_rst_wrap", o_wrap[0], 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
